// File: rtl/spi_master.sv
// spi_master: single-transfer SPI master that runs one full-duplex DATA_W-bit frame, MSB first, in any of the four SPI modes.
// Edge k of the frame toggles SCK CLK_DIV*k cycles after start is accepted, and a hold phase follows the last edge.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        MODE,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              SS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * DATA_W);
  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [EW-1:0] ec;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic cpha, tick, edge_go, lead, last, drive, samp;
  // Edge 1 is generated on leaving SETUP; inside TRANSFER the edge number is ec+2.
  assign tick    = cnt == CW'(CLK_DIV - 1);
  assign edge_go = tick && (state == SETUP || state == TRANSFER);
  assign lead    = state == SETUP || ec[0];
  assign last    = state == TRANSFER && ec == EW'(2 * DATA_W - 2);
  assign drive   = cpha ? lead : !lead && !last;
  assign samp    = lead ^ cpha;
  assign busy    = state == SETUP || state == TRANSFER || state == HOLD;
  assign SS      = !busy;
  assign done    = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = SETUP;
      SETUP:    if (tick) state_nx = TRANSFER;
      TRANSFER: if (tick && last) state_nx = HOLD;
      HOLD:     if (tick) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Both counters restart on every state change, so neither ever wraps.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ec  <= '0;
    end else begin
      cnt <= (state_nx != state || tick) ? '0 : cnt + CW'(1);
      ec  <= state_nx != state ? '0 : edge_go ? ec + EW'(1) : ec;
    end
  // With CPHA=0 the MSB goes out at acceptance, so the shifter is preloaded one bit ahead.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cpha    <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cpha  <= MODE[0];
        SCK   <= MODE[1];
        tx_sr <= MODE[0] ? tx_data : tx_data << 1;
        if (!MODE[0]) MOSI <= tx_data[DATA_W-1];
      end
      if (edge_go) begin
        SCK <= ~SCK;
        if (drive) begin
          MOSI  <= tx_sr[DATA_W-1];
          tx_sr <= tx_sr << 1;
        end
        if (samp) rx_sr <= (rx_sr << 1) | DATA_W'(MISO);
      end
      if (state == HOLD && tick) rx_data <= rx_sr;
    end
endmodule
